// File: rtl/bpf_pkg.sv
// Shared definitions for the BPF packet ingest path: FSM state encoding and stream width.
package bpf_pkg;

    localparam int unsigned STREAM_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FILL  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/packet_filler.sv
// Stream-to-RAM ingest stage: writes one packet into packet_ram per buffer grant.
// Reports word count and truncation with a done pulse once the RAM holds the whole packet.
module packet_filler
    import bpf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [STREAM_WIDTH-1:0] s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    input  logic                    buf_avail,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   word_count,
    output logic                    truncated,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_di,
    output logic                    ram_wr_en,
    output logic                    ram_len_rst
);

    // Top address is never written: the RAM's addr+1 port would wrap onto word 0.
    localparam logic [ADDR_WIDTH-1:0] MAX_WORD = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

    state_e                  r_state;
    logic [ADDR_WIDTH-1:0]   r_wptr;
    logic                    r_done;
    logic [ADDR_WIDTH-1:0]   r_word_count;
    logic                    r_truncated;
    logic [ADDR_WIDTH-1:0]   r_ram_addr;
    logic [DATA_WIDTH-1:0]   r_ram_di;
    logic                    r_ram_wr_en;
    logic                    r_ram_len_rst;

    logic                    w_ready;
    logic                    w_beat;

    assign w_ready = (r_state == FILL) || (r_state == DRAIN);
    assign w_beat  = s_tvalid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_wptr        <= '0;
            r_done        <= 1'b0;
            r_word_count  <= '0;
            r_truncated   <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_di      <= '0;
            r_ram_wr_en   <= 1'b0;
            r_ram_len_rst <= 1'b0;
        end else begin
            r_ram_wr_en   <= 1'b0;
            r_ram_len_rst <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Strobe registered on entry so it is high during the CLEAR cycle itself.
                    if (buf_avail) begin
                        r_state       <= CLEAR;
                        r_ram_len_rst <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_wptr       <= '0;
                    r_truncated  <= 1'b0;
                    r_word_count <= '0;
                    r_state      <= FILL;
                end
                FILL: begin
                    if (w_beat) begin
                        // Low half zeroed; the next word's write overwrites it.
                        r_ram_addr   <= r_wptr;
                        r_ram_di     <= {s_tdata, {(DATA_WIDTH-STREAM_WIDTH){1'b0}}};
                        r_ram_wr_en  <= 1'b1;
                        r_wptr       <= r_wptr + 1'b1;
                        r_word_count <= r_wptr + 1'b1;
                        if (s_tlast) begin
                            r_state <= DONE;
                        end else if (r_wptr == MAX_WORD) begin
                            r_truncated <= 1'b1;
                            r_state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_beat && s_tlast) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_tready    = w_ready;
    assign done        = r_done;
    assign word_count  = r_word_count;
    assign truncated   = r_truncated;
    assign ram_addr    = r_ram_addr;
    assign ram_di      = r_ram_di;
    assign ram_wr_en   = r_ram_wr_en;
    assign ram_len_rst = r_ram_len_rst;

endmodule

// File: tb/tb_packet_filler.sv
// Scoreboard bench for packet_filler at ADDR_WIDTH=4 (MAX_WORD=14): expected writes and
// done reports are queued as beats are accepted and checked when the DUT emits them.
module tb_packet_filler;

    localparam int AW   = 4;
    localparam int DW   = 64;
    localparam int MAXW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic          buf_avail = 1'b0;
    logic          done;
    logic [AW-1:0] word_count;
    logic          truncated;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic          ram_wr_en;
    logic          ram_len_rst;

    packet_filler #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .buf_avail   (buf_avail),
        .done        (done),
        .word_count  (word_count),
        .truncated   (truncated),
        .ram_addr    (ram_addr),
        .ram_di      (ram_di),
        .ram_wr_en   (ram_wr_en),
        .ram_len_rst (ram_len_rst)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_exp_t;

    typedef struct {
        logic [AW-1:0] wc;
        logic          trunc;
        int            cyc;
    } done_exp_t;

    wr_exp_t   wr_q[$];
    done_exp_t done_q[$];
    wr_exp_t   mon_we;
    done_exp_t mon_de;
    int        n_checks = 0;
    int        n_errors = 0;
    int        last_done_cyc = -100;
    logic      prev_len_rst = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wr_en) begin
                check("wr_vs_len_rst", 64'(ram_len_rst), 64'd0);
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 64'(ram_wr_en), 64'd0);
                end else begin
                    mon_we = wr_q.pop_front();
                    check("wr_addr", 64'(ram_addr), 64'(mon_we.addr));
                    check("wr_data", ram_di, mon_we.data);
                    check("wr_cycle", 64'(cyc), 64'(mon_we.cyc));
                end
            end
            if (done) begin
                last_done_cyc = cyc;
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_de = done_q.pop_front();
                    check("done_word_count", 64'(word_count), 64'(mon_de.wc));
                    check("done_truncated", 64'(truncated), 64'(mon_de.trunc));
                    check("done_cycle", 64'(cyc), 64'(mon_de.cyc));
                end
            end
            if (ram_len_rst) check("len_rst_single", 64'(prev_len_rst), 64'd0);
            prev_len_rst = ram_len_rst;
        end
    end

    // Drives n words; the valid pattern advances only on cycles where the DUT is ready.
    task automatic send_pkt(input int n, input logic [31:0] seed, input bit [5:0] pat,
                            input bit with_last, input bit drop_avail);
        int        i = 0;
        int        p = 0;
        int        guard = 0;
        wr_exp_t   we;
        done_exp_t de;
        while (i < n && guard < 400) begin
            s_tvalid = pat[p % 6];
            s_tdata  = s_tvalid ? seed * (i + 1) : 32'hdead_beef;
            s_tlast  = s_tvalid ? (with_last && (i == n - 1)) : 1'b1;
            @(negedge clk);
            if (s_tready) begin
                p++;
                if (drop_avail) buf_avail = 1'b0;
            end
            if (s_tvalid && s_tready) begin
                if (i <= MAXW) begin
                    we.addr = AW'(i);
                    we.data = {seed * (i + 1), 32'h0};
                    we.cyc  = cyc + 1;
                    wr_q.push_back(we);
                end
                if (with_last && (i == n - 1)) begin
                    de.wc    = (n > MAXW + 1) ? AW'(MAXW + 1) : AW'(n);
                    de.trunc = (n > MAXW + 1);
                    de.cyc   = cyc + 2;
                    done_q.push_back(de);
                end
                i++;
            end
            guard++;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("send_accepted", 64'(i), 64'(n));
    endtask

    task automatic wait_done();
        int g = 0;
        while (done_q.size() != 0 && g < 20) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("done_pending", 64'(done_q.size()), 64'd0);
    endtask

    task automatic wait_clear(output int c);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!ram_len_rst && g < 20);
        check("clear_seen", 64'(ram_len_rst), 64'd1);
        c = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_wr_en", 64'(ram_wr_en), 64'd0);
        check("rst_len_rst", 64'(ram_len_rst), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_truncated", 64'(truncated), 64'd0);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_di", ram_di, 64'd0);
        rst_n = 1'b1;

        // Basic 4-word packet.
        buf_avail = 1'b1;
        wait_clear(c);
        buf_avail = 1'b0;
        send_pkt(4, 32'h1111_1111, 6'h3f, 1'b1, 1'b0);
        wait_done();
        check("t1_word_count", 64'(word_count), 64'd4);
        check("t1_truncated", 64'(truncated), 64'd0);

        // Truncation: 20 beats into a 15-word window.
        buf_avail = 1'b1;
        wait_clear(c);
        buf_avail = 1'b0;
        send_pkt(20, 32'h0123_4567, 6'h3f, 1'b1, 1'b0);
        wait_done();
        check("t2_word_count", 64'(word_count), 64'd15);
        check("t2_truncated", 64'(truncated), 64'd1);

        // Exactly MAX_WORD+1 words.
        buf_avail = 1'b1;
        wait_clear(c);
        buf_avail = 1'b0;
        send_pkt(15, 32'h0a0b_0c0d, 6'h3f, 1'b1, 1'b0);
        wait_done();
        check("t3_word_count", 64'(word_count), 64'd15);
        check("t3_truncated", 64'(truncated), 64'd0);

        // Valid toggling 1-0-1-1-0-1.
        buf_avail = 1'b1;
        wait_clear(c);
        buf_avail = 1'b0;
        send_pkt(4, 32'h5a5a_0001, 6'b101101, 1'b1, 1'b0);
        wait_done();
        check("t4_word_count", 64'(word_count), 64'd4);

        // No grant: valid stream must not be accepted.
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = 32'hcafe_f00d;
        repeat (5) begin
            @(negedge clk);
            check("no_grant_tready", 64'(s_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // Grant dropped mid-FILL: packet still completes, no further CLEAR.
        buf_avail = 1'b1;
        wait_clear(c);
        send_pkt(5, 32'h0000_0101, 6'h3f, 1'b1, 1'b1);
        wait_done();
        check("t5_word_count", 64'(word_count), 64'd5);
        repeat (3) begin
            @(negedge clk);
            check("t5_no_reclear", 64'(ram_len_rst), 64'd0);
            check("t5_idle_tready", 64'(s_tready), 64'd0);
        end
        @(posedge clk);
        #1;

        // Grant held high: next CLEAR the cycle after done.
        buf_avail = 1'b1;
        wait_clear(c);
        send_pkt(3, 32'h7777_0003, 6'h3f, 1'b1, 1'b0);
        wait_done();
        wait_clear(c);
        check("b2b_clear_cycle", 64'(c), 64'(last_done_cyc + 1));
        buf_avail = 1'b0;
        send_pkt(2, 32'h1234_0002, 6'h3f, 1'b1, 1'b0);
        wait_done();
        check("b2b_word_count", 64'(word_count), 64'd2);

        // Reset mid-FILL after 3 writes with a 4th write in flight.
        buf_avail = 1'b1;
        wait_clear(c);
        buf_avail = 1'b0;
        send_pkt(3, 32'h0f0f_0f0f, 6'h3f, 1'b0, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 32'hbbbb_bbbb;
        s_tlast  = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(ram_wr_en), 64'd0);
        check("mid_rst_tready", 64'(s_tready), 64'd0);
        check("mid_rst_word_count", 64'(word_count), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_tready", 64'(s_tready), 64'd0);
            check("post_rst_done", 64'(done), 64'd0);
        end

        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
